cv32e40p_hwloop_regs_n: RTL and testbench

Parametrised hardware-loop register file and loop-end controller supporting N_HWLP loops and a configurable counter width, generalising the fixed two-loop arrangement. Holds start/end/count per loop, detects loop-end PCs from the ID stage, selects the innermost active loop, and issues a jump target while decrementing its counter. Sits between the decoder/CSR write path and the ID-stage PC mux.

---
 rtl/cv32e40p_hwloop_regs_n.sv | 176 +++++++++++++++++
 tb/tb_cv32e40p_hwloop_regs_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_hwloop_regs_n.sv
// Hardware-loop register file and loop-end controller for N_HWLP loops; loop 0 is innermost.
// Optional register readback port is enabled by defining CV32E40P_HWLP_READBACK_EN.
module cv32e40p_hwloop_regs_n #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1,
  parameter int COUNT_W     = 32,
  parameter int ADDR_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [1:0]                  wsel_i,
  input  logic [N_HWLP_BITS-1:0]      widx_i,
  input  logic [ADDR_W-1:0]           wdata_i,
  input  logic [COUNT_W-1:0]          wcnt_i,
  input  logic                        clear_i,
  input  logic                        valid_i,
  input  logic [ADDR_W-1:0]           pc_i,
`ifdef CV32E40P_HWLP_READBACK_EN
  input  logic                        ren_i,
  input  logic [N_HWLP_BITS-1:0]      ridx_i,
  input  logic [1:0]                  rsel_i,
  output logic [ADDR_W-1:0]           rdata_o,
  output logic                        rvalid_o,
`endif
  output logic                        jump_o,
  output logic [ADDR_W-1:0]           target_o,
  output logic [N_HWLP-1:0]           active_o,
  output logic [N_HWLP*COUNT_W-1:0]   cnt_o
);

  localparam logic [31:0] N_HWLP_U = 32'(N_HWLP);

  logic [ADDR_W-1:0]      r_start [N_HWLP];
  logic [ADDR_W-1:0]      r_end   [N_HWLP];
  logic [COUNT_W-1:0]     r_cnt   [N_HWLP];
  logic [N_HWLP-1:0]      r_active;

  logic [ADDR_W-1:0]      w_start_nxt [N_HWLP];
  logic [ADDR_W-1:0]      w_end_nxt   [N_HWLP];
  logic [COUNT_W-1:0]     w_cnt_nxt   [N_HWLP];
  logic [N_HWLP-1:0]      w_hit;
  logic [N_HWLP-1:0]      w_wr;
  logic [N_HWLP-1:0]      w_dec;
  logic [N_HWLP_BITS-1:0] w_sel;
  logic                   w_any_hit;
  logic                   w_widx_ok;
  logic [ADDR_W-1:0]      w_pc4;
  logic [ADDR_W-1:0]      w_wdata_al;
  logic [ADDR_W-1:0]      w_pc4_al;

  assign w_widx_ok  = ({{(32-N_HWLP_BITS){1'b0}}, widx_i} < N_HWLP_U);
  assign w_pc4      = pc_i + ADDR_W'(4);
  assign w_wdata_al = {wdata_i[ADDR_W-1:1], 1'b0};
  assign w_pc4_al   = {w_pc4[ADDR_W-1:1], 1'b0};

  // Loop-end match and innermost-first selection; scanning downward leaves the lowest hit index.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      w_hit[i] = (pc_i == r_end[i]) && (r_cnt[i] != '0);
    end
    for (int i = N_HWLP - 1; i >= 0; i--) begin
      w_sel = w_hit[i] ? N_HWLP_BITS'(i) : w_sel;
    end
    w_any_hit = |w_hit;
  end

  // Loop-back jump, from pre-update state; the final iteration (count 1) falls through.
  always_comb begin
    if (valid_i && w_any_hit && (r_cnt[w_sel] > COUNT_W'(1))) begin
      jump_o   = 1'b1;
      target_o = r_start[w_sel];
    end else begin
      jump_o   = 1'b0;
      target_o = '0;
    end
  end

  // Next-state per loop: clear beats any write, a write to a loop swallows its decrement.
  always_comb begin
    for (int i = 0; i < N_HWLP; i++) begin
      w_wr[i]        = we_i && w_widx_ok && (widx_i == N_HWLP_BITS'(i));
      w_dec[i]       = valid_i && w_any_hit && (w_sel == N_HWLP_BITS'(i));
      w_start_nxt[i] = r_start[i];
      w_end_nxt[i]   = r_end[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_wr[i]) begin
        case (wsel_i)
          2'd0:    w_start_nxt[i] = w_wdata_al;
          2'd1:    w_end_nxt[i]   = w_wdata_al;
          2'd3: begin
            w_start_nxt[i] = w_pc4_al;
            w_end_nxt[i]   = w_wdata_al;
          end
          default: w_start_nxt[i] = r_start[i];
        endcase
      end else begin
        w_start_nxt[i] = r_start[i];
      end
      if (clear_i) begin
        w_cnt_nxt[i] = '0;
      end else if (w_wr[i] && ((wsel_i == 2'd2) || (wsel_i == 2'd3))) begin
        w_cnt_nxt[i] = wcnt_i;
      end else if (w_wr[i]) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - COUNT_W'(1);
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Loop register state; the active flags are registered alongside the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_HWLP; i++) begin
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_cnt[i]   <= '0;
      end
      r_active <= '0;
    end else begin
      for (int i = 0; i < N_HWLP; i++) begin
        r_start[i]  <= w_start_nxt[i];
        r_end[i]    <= w_end_nxt[i];
        r_cnt[i]    <= w_cnt_nxt[i];
        r_active[i] <= (w_cnt_nxt[i] != '0);
      end
    end
  end

  assign active_o = r_active;

  genvar g;
  generate
    for (g = 0; g < N_HWLP; g++) begin : g_cnt_pack
      assign cnt_o[g*COUNT_W +: COUNT_W] = r_cnt[g];
    end
  endgenerate

`ifdef CV32E40P_HWLP_READBACK_EN
  logic [ADDR_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              w_ridx_ok;

  assign w_ridx_ok = ({{(32-N_HWLP_BITS){1'b0}}, ridx_i} < N_HWLP_U);

  // Readback samples current register values, so a same-cycle write is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= ren_i;
      if (ren_i && w_ridx_ok) begin
        case (rsel_i)
          2'd0:    r_rdata <= r_start[ridx_i];
          2'd1:    r_rdata <= r_end[ridx_i];
          2'd2:    r_rdata <= ADDR_W'(r_cnt[ridx_i]);
          default: r_rdata <= '0;
        endcase
      end else if (ren_i) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_regs_n.sv
// Directed self-checking bench for cv32e40p_hwloop_regs_n (two loops, 32-bit counters/addresses).
module tb_cv32e40p_hwloop_regs_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [1:0]  wsel_i;
  logic [0:0]  widx_i;
  logic [31:0] wdata_i;
  logic [31:0] wcnt_i;
  logic        clear_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        jump_o;
  logic [31:0] target_o;
  logic [1:0]  active_o;
  logic [63:0] cnt_o;
`ifdef CV32E40P_HWLP_READBACK_EN
  logic        ren_i;
  logic [0:0]  ridx_i;
  logic [1:0]  rsel_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cv32e40p_hwloop_regs_n #(.N_HWLP(2), .COUNT_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .wsel_i(wsel_i), .widx_i(widx_i),
    .wdata_i(wdata_i), .wcnt_i(wcnt_i), .clear_i(clear_i), .valid_i(valid_i),
    .pc_i(pc_i),
`ifdef CV32E40P_HWLP_READBACK_EN
    .ren_i(ren_i), .ridx_i(ridx_i), .rsel_i(rsel_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
`endif
    .jump_o(jump_o), .target_o(target_o), .active_o(active_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [0:0] idx,
                    input logic [31:0] data, input logic [31:0] cnt, input logic [31:0] pc);
    we_i = 1'b1; wsel_i = sel; widx_i = idx; wdata_i = data; wcnt_i = cnt; pc_i = pc;
    step();
    we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; wsel_i = 2'd0; widx_i = 1'b0; wdata_i = 32'h0;
    wcnt_i = 32'h0; clear_i = 1'b0; valid_i = 1'b0; pc_i = 32'h0;
`ifdef CV32E40P_HWLP_READBACK_EN
    ren_i = 1'b0; ridx_i = 1'b0; rsel_i = 2'd0;
`endif
    step(); step();
    rst = 1'b0;
    chk("rst_jump", {63'd0, jump_o}, 64'd0);
    chk("rst_target", {32'd0, target_o}, 64'd0);
    chk("rst_active", {62'd0, active_o}, 64'd0);
    chk("rst_cnt", cnt_o, 64'd0);

    // Idle with random PCs: nothing is armed, so nothing may happen.
    for (int k = 0; k < 10; k++) begin
      pc_i = $urandom; valid_i = 1'($urandom_range(1, 0));
      #1;
      chk("idle_jump", {63'd0, jump_o}, 64'd0);
      step();
      chk("idle_active", {62'd0, active_o}, 64'd0);
      chk("idle_cnt", cnt_o, 64'd0);
    end
    valid_i = 1'b0;

    // Single loop via setup write: start=0x104, end=0x120, count=3.
    wr(2'd3, 1'b0, 32'h120, 32'd3, 32'h100);
    chk("setup_cnt", cnt_o, 64'd3);
    chk("setup_active", {62'd0, active_o}, 64'd1);
    valid_i = 1'b1; pc_i = 32'h120;
    #1;
    chk("l0_it1_jump", {63'd0, jump_o}, 64'd1);
    chk("l0_it1_target", {32'd0, target_o}, 64'h104);
    step();
    chk("l0_it1_cnt", cnt_o, 64'd2);
    chk("l0_it2_jump", {63'd0, jump_o}, 64'd1);
    chk("l0_it2_target", {32'd0, target_o}, 64'h104);
    step();
    chk("l0_it2_cnt", cnt_o, 64'd1);
    chk("l0_it3_jump", {63'd0, jump_o}, 64'd0);
    chk("l0_it3_target", {32'd0, target_o}, 64'd0);
    step();
    chk("l0_it3_cnt", cnt_o, 64'd0);
    chk("l0_it3_active", {62'd0, active_o}, 64'd0);
    chk("l0_done_jump", {63'd0, jump_o}, 64'd0);
    valid_i = 1'b0;

    // Nested loops sharing end 0x200; end0 written as 0x201 to exercise bit-0 masking.
    wr(2'd0, 1'b0, 32'h1F0, 32'd0, 32'h0);
    wr(2'd1, 1'b0, 32'h201, 32'd0, 32'h0);
    wr(2'd2, 1'b0, 32'h0, 32'd2, 32'h0);
    wr(2'd3, 1'b1, 32'h200, 32'd5, 32'h1E0);
    chk("nest_cnt0", cnt_o, {32'd5, 32'd2});
    chk("nest_active", {62'd0, active_o}, 64'd3);
    valid_i = 1'b1; pc_i = 32'h200;
    #1;
    chk("nest_jump_a", {63'd0, jump_o}, 64'd1);
    chk("nest_target_a", {32'd0, target_o}, 64'h1F0);
    step();
    chk("nest_cnt_a", cnt_o, {32'd5, 32'd1});
    chk("nest_jump_b", {63'd0, jump_o}, 64'd0);
    step();
    chk("nest_cnt_b", cnt_o, {32'd5, 32'd0});
    chk("nest_active_b", {62'd0, active_o}, 64'd2);
    chk("nest_jump_c", {63'd0, jump_o}, 64'd1);
    chk("nest_target_c", {32'd0, target_o}, 64'h1E4);
    step();
    chk("nest_cnt_c", cnt_o, {32'd4, 32'd0});
    valid_i = 1'b0;

    // Write-vs-decrement: same loop keeps the written value; other loop coexists.
    wr(2'd2, 1'b0, 32'h0, 32'd3, 32'h0);
    valid_i = 1'b1; pc_i = 32'h200;
    we_i = 1'b1; wsel_i = 2'd2; widx_i = 1'b0; wcnt_i = 32'd7;
    #1;
    chk("wdec_jump", {63'd0, jump_o}, 64'd1);
    step();
    chk("wdec_same", cnt_o, {32'd4, 32'd7});
    widx_i = 1'b1; wcnt_i = 32'd9;
    step();
    we_i = 1'b0;
    chk("wdec_other", cnt_o, {32'd9, 32'd6});

    // valid_i low: no jump, no decrement.
    valid_i = 1'b0;
    #1;
    chk("novalid_jump", {63'd0, jump_o}, 64'd0);
    step();
    chk("novalid_cnt", cnt_o, {32'd9, 32'd6});

    // Clear: jump uses pre-clear state, counters zeroed, start/end retained.
    wr(2'd2, 1'b0, 32'h0, 32'd4, 32'h0);
    valid_i = 1'b1; pc_i = 32'h200; clear_i = 1'b1;
    #1;
    chk("clr_jump", {63'd0, jump_o}, 64'd1);
    chk("clr_target", {32'd0, target_o}, 64'h1F0);
    step();
    clear_i = 1'b0;
    chk("clr_cnt", cnt_o, 64'd0);
    chk("clr_active", {62'd0, active_o}, 64'd0);
    chk("clr_jump_after", {63'd0, jump_o}, 64'd0);
    valid_i = 1'b0;
    wr(2'd2, 1'b0, 32'h0, 32'd2, 32'h0);
    valid_i = 1'b1; pc_i = 32'h200;
    #1;
    chk("clr_keep_jump", {63'd0, jump_o}, 64'd1);
    chk("clr_keep_target", {32'd0, target_o}, 64'h1F0);
    valid_i = 1'b0;
    step();
    chk("clr_keep_cnt", cnt_o, 64'd2);

`ifdef CV32E40P_HWLP_READBACK_EN
    wr(2'd2, 1'b1, 32'h0, 32'd5, 32'h0);
    ren_i = 1'b1; ridx_i = 1'b1; rsel_i = 2'd2;
    step();
    ren_i = 1'b0;
    chk("rb_cnt1", {32'd0, rdata_o}, 64'd5);
    chk("rb_valid", {63'd0, rvalid_o}, 64'd1);
    ren_i = 1'b1; ridx_i = 1'b0; rsel_i = 2'd0;
    step();
    ren_i = 1'b0;
    chk("rb_start0", {32'd0, rdata_o}, 64'h1F0);
    step();
    chk("rb_valid_low", {63'd0, rvalid_o}, 64'd0);
`endif

    // Mid-operation reset discards a pending count write.
    we_i = 1'b1; wsel_i = 2'd2; widx_i = 1'b0; wcnt_i = 32'd5; rst = 1'b1;
    step();
    we_i = 1'b0; rst = 1'b0;
    chk("midrst_cnt", cnt_o, 64'd0);
    chk("midrst_active", {62'd0, active_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
